// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with status flags and valid/ready flow control.
// Optional signed saturation (op[1]) is built only when PREFIX_ADDER_SAT_EN is defined.
module prefix_adder_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int LV = $clog2(WIDTH);
    localparam int PW = 1 << LV;

    // Handshake: a beat moves on any edge where in_valid & in_ready; the whole
    // pipe advances together when the output slot is empty or being consumed.
    typedef struct packed {
        logic          v;
        logic          c0;
        logic          amsb;
        logic          sat;
        logic [PW-1:0] x;
        logic [PW-1:0] g;
        logic [PW-1:0] p;
    } stage_t;

    // Apply prefix levels lo..hi-1 of the Kogge-Stone network.
    function automatic stage_t ks_levels(stage_t s, int lo, int hi);
        stage_t        r;
        logic [PW-1:0] g_old;
        logic [PW-1:0] p_old;
        r = s;
        for (int l = 0; l < LV; l++) begin
            if (l >= lo && l < hi) begin
                g_old = r.g;
                p_old = r.p;
                for (int i = (1 << l); i < PW; i++) begin
                    r.g[i] = g_old[i] | (p_old[i] & g_old[i-(1<<l)]);
                    r.p[i] = p_old[i] & p_old[i-(1<<l)];
                end
            end
        end
        return r;
    endfunction

    function automatic int bnd(int k);
        return (k * LV) / LATENCY;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    stage_t           prep;
    stage_t           src [LATENCY];
    stage_t           fin;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;
    assign b_eff    = op[0] ? ~b : b;
    assign c0       = op[0] | cin;

    // The carry-in is folded into bit 0's generate, so clog2(WIDTH) levels
    // suffice; padding bits above WIDTH stay p=0, g=0.
    always_comb begin
        prep                = '0;
        prep.v              = in_valid;
        prep.c0             = c0;
        prep.amsb           = a[WIDTH-1];
        prep.x[WIDTH-1:0]   = a ^ b_eff;
        prep.g[WIDTH-1:0]   = a & b_eff;
        prep.g[0]           = prep.g[0] | (prep.x[0] & c0);
        prep.p              = prep.x;
`ifdef PREFIX_ADDER_SAT_EN
        prep.sat            = op[1];
`endif
    end

`ifndef PREFIX_ADDER_SAT_EN
    logic unused_op1;
    assign unused_op1 = op[1];
`endif

    assign src[0] = prep;

    for (genvar k = 0; k < LATENCY - 1; k++) begin : g_stage
        stage_t r;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r <= '0;
            end else if (advance) begin
                r <= ks_levels(src[k], bnd(k), bnd(k + 1));
            end
        end
        assign src[k+1] = r;
    end

    assign fin = ks_levels(src[LATENCY-1], bnd(LATENCY - 1), LV);

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_sum;
    logic             raw_cout;
    logic             raw_ovf;
    logic             unused_fin;

    assign unused_fin = ^fin;

    always_comb begin
        carry    = {fin.g[WIDTH-2:0], fin.c0};
        raw_sum  = fin.x[WIDTH-1:0] ^ carry;
        raw_cout = fin.g[WIDTH-1];
        raw_ovf  = carry[WIDTH-1] ^ raw_cout;
        res_sum  = raw_sum;
`ifdef PREFIX_ADDER_SAT_EN
        if (fin.sat && raw_ovf) begin
            res_sum = fin.amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Output register: data only loads for real beats so bubbles leave it quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (advance) begin
            out_valid <= fin.v;
            if (fin.v) begin
                sum  <= res_sum;
                cout <= raw_cout;
                ovf  <= raw_ovf;
                zero <= (res_sum == '0);
                neg  <= res_sum[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: three configurations (32/2, 8/1, 24/4), vector table,
// hand sequences for stall, latency and reset, and a scoreboard fed at acceptance.
module tb_prefix_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [3];
    logic        in_ready [3];
    logic [31:0] a_in [3];
    logic [31:0] b_in [3];
    logic        cin [3];
    logic [1:0]  op [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        cout [3];
    logic        ovf [3];
    logic        zero [3];
    logic        neg [3];
    logic [31:0] sum0;
    logic [7:0]  sum1;
    logic [23:0] sum2;

    int n_tests = 0;
    int n_fail  = 0;
    logic rnd_en = 1'b0;

    logic [35:0] exp_q0[$];
    logic [35:0] exp_q1[$];
    logic [35:0] exp_q2[$];

    always #5 clk = ~clk;

    prefix_adder_pipe #(.WIDTH(32), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_in[0]), .b(b_in[0]), .cin(cin[0]), .op(op[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum0),
        .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0]), .neg(neg[0]));

    prefix_adder_pipe #(.WIDTH(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_in[1][7:0]), .b(b_in[1][7:0]), .cin(cin[1]), .op(op[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum1),
        .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1]), .neg(neg[1]));

    prefix_adder_pipe #(.WIDTH(24), .LATENCY(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_in[2][23:0]), .b(b_in[2][23:0]), .cin(cin[2]), .op(op[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum2),
        .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2]), .neg(neg[2]));

    function automatic int wid(int k);
        return (k == 0) ? 32 : (k == 1) ? 8 : 24;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] get_sum(int k);
        return (k == 0) ? sum0 : (k == 1) ? {24'd0, sum1} : {8'd0, sum2};
    endfunction

    function automatic logic [35:0] got_vec(int k);
        return {get_sum(k), cout[k], ovf[k], zero[k], neg[k]};
    endfunction

    // Reference: plain wide addition, flags derived from operand/result signs.
    function automatic logic [35:0] model(int w, logic [31:0] av, logic [31:0] bv,
                                          logic c, logic [1:0] o);
        logic [32:0] full;
        logic [31:0] mask, aa, bp, s;
        logic        c0, co, ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa   = av & mask;
        bp   = (o[0] ? ~bv : bv) & mask;
        c0   = o[0] ? 1'b1 : c;
        full = {1'b0, aa} + {1'b0, bp} + {32'd0, c0};
        s    = full[31:0] & mask;
        co   = full[w];
        ov   = (aa[w-1] == bp[w-1]) && (s[w-1] != aa[w-1]);
`ifdef PREFIX_ADDER_SAT_EN
        if (o[1] && ov) s = aa[w-1] ? (32'd1 << (w - 1)) : ((32'd1 << (w - 1)) - 32'd1);
`endif
        return {s, co, ov, (s == 32'd0), s[w-1]};
    endfunction

    task automatic check(string name, logic [35:0] act, logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(int k, logic [35:0] e);
        case (k)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(int k, output logic ok, output logic [35:0] e);
        ok = 1'b0;
        e  = '0;
        case (k)
            0:       if (exp_q0.size() > 0) begin ok = 1'b1; e = exp_q0.pop_front(); end
            1:       if (exp_q1.size() > 0) begin ok = 1'b1; e = exp_q1.pop_front(); end
            default: if (exp_q2.size() > 0) begin ok = 1'b1; e = exp_q2.pop_front(); end
        endcase
    endtask

    // Inputs change 1 time unit after a falling edge; acceptance is decided by
    // in_ready at that point and happens on the following rising edge.
    task automatic send(int k, logic [31:0] av, logic [31:0] bv, logic c,
                        logic [1:0] o, logic [35:0] e);
        int guard;
        @(negedge clk); #1;
        in_valid[k] = 1'b1;
        a_in[k]     = av;
        b_in[k]     = bv;
        cin[k]      = c;
        op[k]       = o;
        guard       = 0;
        while (!in_ready[k] && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!in_ready[k]) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: in_ready stayed 0, required 1", k);
        end else begin
            push_exp(k, e);
        end
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic send_model(int k, logic [31:0] av, logic [31:0] bv, logic c, logic [1:0] o);
        logic [31:0] mask;
        mask = (wid(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(k)) - 32'd1);
        send(k, av & mask, bv & mask, c, o, model(wid(k), av, bv, c, o));
    endtask

    task automatic latency_check(int k, logic [31:0] av, logic [31:0] bv);
        logic [35:0] e;
        e = model(wid(k), av, bv, 1'b0, 2'b00);
        send_model(k, av, bv, 1'b0, 2'b00);
        for (int j = 1; j < lat(k); j++) begin
            @(negedge clk); #3;
            check($sformatf("lat_early_dut%0d", k), 36'(out_valid[k]), 36'd0);
        end
        @(negedge clk); #3;
        check($sformatf("lat_valid_dut%0d", k), 36'(out_valid[k]), 36'd1);
        check($sformatf("lat_data_dut%0d", k), got_vec(k), e);
    endtask

    task automatic stall_stream(int k);
        fork
            begin
                for (int i = 1; i <= 4; i++) send_model(k, 32'(i), 32'(i), 1'b0, 2'b00);
            end
            begin
                int guard = 0;
                @(negedge clk);
                while (!out_valid[k] && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                if (!out_valid[k]) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stall_first_result dut%0d: out_valid stayed 0, required 1", k);
                end else begin
                    out_ready[k] = 1'b0;
                    for (int c = 0; c < 2; c++) begin
                        @(negedge clk); #3;
                        check($sformatf("stall_valid_dut%0d", k), 36'(out_valid[k]), 36'd1);
                        check($sformatf("stall_sum_dut%0d", k), 36'(get_sum(k)), 36'd2);
                        check($sformatf("stall_in_ready_dut%0d", k), 36'(in_ready[k]), 36'd0);
                    end
                    @(negedge clk);
                    out_ready[k] = 1'b1;
                    for (int i = 1; i <= 4; i++) begin
                        #3;
                        check($sformatf("stream_valid_dut%0d_%0d", k, i), 36'(out_valid[k]), 36'd1);
                        check($sformatf("stream_sum_dut%0d_%0d", k, i), 36'(get_sum(k)), 36'(2 * i));
                        @(negedge clk);
                    end
                end
            end
        join
    endtask

    // Scoreboard: compares every result transfer against the head of its queue.
    logic [35:0] mon_exp;
    logic        mon_ok;
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    pop_exp(k, mon_ok, mon_exp);
                    if (!mon_ok) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected dut%0d: got %h, required no result", k, got_vec(k));
                    end else begin
                        check($sformatf("sb_dut%0d", k), got_vec(k), mon_exp);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rnd_en) begin
            for (int k = 0; k < 3; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [1:0]  op;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{32'hFFFF_FFFF, 32'h1, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h7FFF_FFFF, 32'h1, 1'b0, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h0000_FFFF, 32'h0, 1'b1, 2'b00, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h5,         32'h7, 1'b0, 2'b01, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h5,         32'h7, 1'b1, 2'b01, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h7,         32'h5, 1'b0, 2'b01, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h7,         32'h5, 1'b1, 2'b01, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'h1, 1'b0, 2'b01, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef PREFIX_ADDER_SAT_EN
        vecs[8]  = '{32'h7FFF_FFFF, 32'h1, 1'b0, 2'b10, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h1, 1'b0, 2'b11, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[8]  = '{32'h7FFF_FFFF, 32'h1, 1'b0, 2'b10, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{32'h8000_0000, 32'h1, 1'b0, 2'b11, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        vecs[10] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 2'b00, 32'hACF1_3569, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 2'b01, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};

        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            a_in[k]      = '0;
            b_in[k]      = '0;
            cin[k]       = 1'b0;
            op[k]        = 2'b00;
        end
        rst_n = 1'b0;

        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid_dut%0d", k), 36'(out_valid[k]), 36'd0);
            check($sformatf("rst_data_dut%0d", k), got_vec(k), 36'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #3;
        for (int k = 0; k < 3; k++) check($sformatf("post_rst_ready_dut%0d", k), 36'(in_ready[k]), 36'd1);

        for (int i = 0; i < 13; i++) begin
            send(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op,
                 {vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].neg});
        end
        repeat (8) @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            latency_check(k, 32'hFFFF_FFFF, 32'h1);
            repeat (6) @(negedge clk);
        end

        for (int k = 0; k < 3; k++) begin
            stall_stream(k);
            repeat (8) @(negedge clk);
        end

        send_model(0, 32'd10, 32'd1, 1'b0, 2'b00);
        send_model(0, 32'd20, 32'd2, 1'b0, 2'b00);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 36'(out_valid[0]), 36'd0);
        check("midrst_data", got_vec(0), 36'd0);
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < lat(0) + 3; j++) begin
            @(negedge clk); #3;
            check("midrst_no_stale", 36'(out_valid[0]), 36'd0);
        end
        latency_check(0, 32'd3, 32'd4);
        check("midrst_new_sum", 36'(get_sum(0)), 36'd7);
        repeat (6) @(negedge clk);

        rnd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 25; i++) begin
                send_model(k, $urandom, $urandom, 1'($urandom_range(0, 1)),
                           2'($urandom_range(0, 3)));
            end
        end
        rnd_en = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
        repeat (20) @(negedge clk);
        check("drain_q0", 36'(exp_q0.size()), 36'd0);
        check("drain_q1", 36'(exp_q1.size()), 36'd0);
        check("drain_q2", 36'(exp_q2.size()), 36'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
